// File: rtl/aes_req_scheduler_pkg.sv
// ---------------------------------------------------------------------------
// aes_req_scheduler_pkg
//   Shared types and constants for the AES request scheduler slice.
//   AES_W          : AES block / key width in bits
//   sched_state_t  : scheduler FSM state encoding
//   onehot()       : index -> one-hot helper used for grant/response vectors
// ---------------------------------------------------------------------------
package aes_req_scheduler_pkg;

   localparam int AES_W = 128;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_LOAD = 2'd1,
      S_BUSY = 2'd2,
      S_RESP = 2'd3
   } sched_state_t;

   function automatic logic [7:0] onehot(input logic [2:0] idx);
      logic [7:0] v;
      v      = '0;
      v[idx] = 1'b1;
      return v;
   endfunction

endpackage

// File: rtl/aes_req_scheduler_if.sv
// ---------------------------------------------------------------------------
// aes_req_scheduler_if
//   Client-side bundle of the scheduler: per-requester job channel
//   (valid/ready + key/text/mode) and the shared response channel.
//   master : the requesters (drive jobs, take responses)
//   slave  : the scheduler
// ---------------------------------------------------------------------------
interface aes_req_scheduler_if #(
   parameter int NUM_REQ = 4
);
   import aes_req_scheduler_pkg::*;

   logic [NUM_REQ-1:0]       req_valid;
   logic [NUM_REQ-1:0]       req_ready;
   logic [NUM_REQ*AES_W-1:0] req_key;
   logic [NUM_REQ*AES_W-1:0] req_text;
   logic [NUM_REQ-1:0]       req_mode;
   logic [NUM_REQ-1:0]       rsp_valid;
   logic [NUM_REQ-1:0]       rsp_ready;
   logic [AES_W-1:0]         rsp_text;
   logic                     rsp_err;

   modport master (
      output req_valid, req_key, req_text, req_mode, rsp_ready,
      input  req_ready, rsp_valid, rsp_text, rsp_err
   );

   modport slave (
      input  req_valid, req_key, req_text, req_mode, rsp_ready,
      output req_ready, rsp_valid, rsp_text, rsp_err
   );

endinterface

// File: rtl/aes_req_scheduler_rr_arbiter.sv
// ---------------------------------------------------------------------------
// aes_req_scheduler_rr_arbiter
//   Round-robin pick: first set bit of i_req searching upward from
//   i_ptr+1, wrapping modulo N. Purely combinational.
//   i_req   : request vector
//   i_ptr   : index of the last requester served
//   o_gnt   : one-hot grant (all zero when no request)
//   o_idx   : binary index of the grant
//   o_any   : at least one request present
// ---------------------------------------------------------------------------
module aes_req_scheduler_rr_arbiter #(
   parameter int N  = 4,
   parameter int IW = $clog2(N)
) (
   input  logic [N-1:0]  i_req,
   input  logic [IW-1:0] i_ptr,
   output logic [N-1:0]  o_gnt,
   output logic [IW-1:0] o_idx,
   output logic          o_any
);

   logic          w_found;
   logic [IW-1:0] w_idx;
   logic [IW-1:0] w_cand;

   always_comb begin
      w_found = 1'b0;
      w_idx   = '0;
      w_cand  = '0;
      // k runs 1..N so the last-served requester is considered last
      for (int k = 1; k <= N; k++) begin
         w_cand = IW'((int'(i_ptr) + k) % N);
         if (!w_found && i_req[w_cand]) begin
            w_found = 1'b1;
            w_idx   = w_cand;
         end
      end
   end

   assign o_any = w_found;
   assign o_idx = w_idx;
   assign o_gnt = w_found ? (N'(1) << w_idx) : '0;

endmodule

// File: rtl/aes_req_scheduler.sv
// ---------------------------------------------------------------------------
// aes_req_scheduler
//   Shares one AES core between NUM_REQ requesters. Round-robin grant,
//   latches the winner's key/text/mode, pulses the core load, waits for
//   done (or a timeout) and returns the result over the response channel.
//
//   clk          : system clock, posedge
//   rst          : asynchronous reset, active-low
//   bus          : client job/response bundle (slave side)
//   core_ld_o    : one-cycle load pulse to the core
//   core_key_o   : latched key, stable from LOAD until back in IDLE
//   core_text_o  : latched text, stable likewise
//   core_mode_o  : latched mode (1 = encrypt), stable likewise
//   core_done_i  : core completion strobe, honoured only in BUSY
//   core_text_i  : core result, sampled with core_done_i
//   busy_o       : 1 in every state except IDLE
//
//   state  | meaning
//   S_IDLE | waiting for any req_valid; grant is combinational
//   S_LOAD | core_ld_o high for this single cycle, wait counter cleared
//   S_BUSY | counting cycles until core_done_i or timeout
//   S_RESP | rsp_valid[g] held until rsp_ready[g]
// ---------------------------------------------------------------------------
module aes_req_scheduler
   import aes_req_scheduler_pkg::*;
#(
   parameter int NUM_REQ     = 4,
   parameter int TIMEOUT_CYC = 64
) (
   input  logic               clk,
   input  logic               rst,
   aes_req_scheduler_if.slave bus,
   output logic               core_ld_o,
   output logic [AES_W-1:0]   core_key_o,
   output logic [AES_W-1:0]   core_text_o,
   output logic               core_mode_o,
   input  logic               core_done_i,
   input  logic [AES_W-1:0]   core_text_i,
   output logic               busy_o
);

   localparam int IW = $clog2(NUM_REQ);
   localparam int CW = $clog2(TIMEOUT_CYC) + 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYC - 1);
   localparam logic [CW-1:0] CNT_MAX  = '1;

   sched_state_t       r_state;
   sched_state_t       w_state_nxt;

   logic [IW-1:0]      r_ptr;
   logic [IW-1:0]      r_gnt_idx;
   logic [AES_W-1:0]   r_key;
   logic [AES_W-1:0]   r_text;
   logic               r_mode;
   logic [CW-1:0]      r_cnt;
   logic [NUM_REQ-1:0] r_rsp_valid;
   logic [AES_W-1:0]   r_rsp_text;
   logic               r_rsp_err;

   logic [NUM_REQ-1:0] w_gnt;
   logic [IW-1:0]      w_gnt_idx;
   logic               w_any;
   logic [NUM_REQ-1:0] w_req_ready;
   logic               w_timeout;
   logic               w_rsp_hs;

   aes_req_scheduler_rr_arbiter #(
      .N  (NUM_REQ),
      .IW (IW)
   ) u_arb (
      .i_req (bus.req_valid),
      .i_ptr (r_ptr),
      .o_gnt (w_gnt),
      .o_idx (w_gnt_idx),
      .o_any (w_any)
   );

   assign w_timeout = (r_cnt == CNT_LAST);
   assign w_rsp_hs  = bus.rsp_ready[r_gnt_idx];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_req_ready = '0;
      unique case (r_state)
         S_IDLE: begin
            if (w_any) begin
               w_req_ready = w_gnt;
               w_state_nxt = S_LOAD;
            end
         end
         S_LOAD: w_state_nxt = S_BUSY;
         S_BUSY: begin
            if (core_done_i || w_timeout) begin
               w_state_nxt = S_RESP;
            end
         end
         S_RESP: begin
            if (w_rsp_hs) begin
               w_state_nxt = S_IDLE;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_ptr       <= IW'(NUM_REQ - 1);
         r_gnt_idx   <= '0;
         r_key       <= '0;
         r_text      <= '0;
         r_mode      <= 1'b0;
         r_cnt       <= '0;
         r_rsp_valid <= '0;
         r_rsp_text  <= '0;
         r_rsp_err   <= 1'b0;
      end else begin
         unique case (r_state)
            S_IDLE: begin
               if (w_any) begin
                  r_gnt_idx <= w_gnt_idx;
                  r_key     <= bus.req_key[int'(w_gnt_idx)*AES_W +: AES_W];
                  r_text    <= bus.req_text[int'(w_gnt_idx)*AES_W +: AES_W];
                  r_mode    <= bus.req_mode[w_gnt_idx];
               end
            end
            S_LOAD: begin
               r_cnt <= '0;
            end
            S_BUSY: begin
               if (r_cnt != CNT_MAX) begin
                  r_cnt <= r_cnt + 1'b1;
               end
               // done has priority over a timeout landing on the same cycle
               if (core_done_i) begin
                  r_rsp_text  <= core_text_i;
                  r_rsp_err   <= 1'b0;
                  r_rsp_valid <= NUM_REQ'(1) << r_gnt_idx;
               end else if (w_timeout) begin
                  r_rsp_text  <= '0;
                  r_rsp_err   <= 1'b1;
                  r_rsp_valid <= NUM_REQ'(1) << r_gnt_idx;
               end
            end
            S_RESP: begin
               if (w_rsp_hs) begin
                  r_rsp_valid <= '0;
                  r_ptr       <= r_gnt_idx;
               end
            end
            default: ;
         endcase
      end
   end

   // the grant is combinational from req_valid, so hold it off while reset
   // is asserted to keep every output at zero during reset
   assign bus.req_ready = rst ? w_req_ready : '0;
   assign bus.rsp_valid = r_rsp_valid;
   assign bus.rsp_text  = r_rsp_text;
   assign bus.rsp_err   = r_rsp_err;

   assign core_ld_o   = (r_state == S_LOAD);
   assign core_key_o  = r_key;
   assign core_text_o = r_text;
   assign core_mode_o = r_mode;
   assign busy_o      = (r_state != S_IDLE);

endmodule

// File: tb/tb_aes_req_scheduler.sv
module tb_aes_req_scheduler;
   import aes_req_scheduler_pkg::*;

   localparam int N  = 4;
   localparam int TO = 64;

   localparam logic [127:0] FIPS_K = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] FIPS_T = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] FIPS_C = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

   logic         clk = 1'b0;
   logic         rst;
   logic         core_ld;
   logic [127:0] core_key;
   logic [127:0] core_text_out;
   logic         core_mode;
   logic         core_done;
   logic [127:0] core_text_in;
   logic         busy;

   always #5 clk = ~clk;

   aes_req_scheduler_if #(.NUM_REQ(N)) bus ();

   aes_req_scheduler #(
      .NUM_REQ     (N),
      .TIMEOUT_CYC (TO)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .bus         (bus),
      .core_ld_o   (core_ld),
      .core_key_o  (core_key),
      .core_text_o (core_text_out),
      .core_mode_o (core_mode),
      .core_done_i (core_done),
      .core_text_i (core_text_in),
      .busy_o      (busy)
   );

   int n_tests = 0;
   int n_fail  = 0;

   // reference model: pending jobs per requester and last-served pointer
   bit           pending  [N];
   logic [127:0] job_key  [N];
   logic [127:0] job_text [N];
   logic         job_mode [N];
   int           exp_ptr;

   task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [N-1:0] oh(input int i);
      logic [N-1:0] v;
      v = '0;
      if (i >= 0 && i < N) v[i] = 1'b1;
      return v;
   endfunction

   function automatic logic [127:0] rand128();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   // behavioural stand-in for the AES core
   function automatic logic [127:0] core_fn(input logic [127:0] k, input logic [127:0] t, input logic m);
      if (k == FIPS_K && t == FIPS_T && m) return FIPS_C;
      return m ? (k ^ {t[63:0], t[127:64]}) : (k - t);
   endfunction

   function automatic int model_grant();
      for (int k = 1; k <= N; k++) begin
         if (pending[(exp_ptr + k) % N]) return (exp_ptr + k) % N;
      end
      return -1;
   endfunction

   task automatic new_job(input int i);
      pending[i]  = 1'b1;
      job_key[i]  = rand128();
      job_text[i] = rand128();
      job_mode[i] = 1'($urandom_range(0, 1));
   endtask

   task automatic drive_reqs();
      for (int i = 0; i < N; i++) begin
         bus.req_valid[i]            = pending[i];
         bus.req_key[i*128 +: 128]   = job_key[i];
         bus.req_text[i*128 +: 128]  = job_text[i];
         bus.req_mode[i]             = job_mode[i];
      end
   endtask

   task automatic chk_outputs_zero();
      chk("rst_ld",        core_ld,       1'b0);
      chk("rst_busy",      busy,          1'b0);
      chk("rst_rsp_valid", bus.rsp_valid, '0);
      chk("rst_rsp_err",   bus.rsp_err,   1'b0);
      chk("rst_rsp_text",  bus.rsp_text,  '0);
      chk("rst_core_key",  core_key,      '0);
      chk("rst_core_text", core_text_out, '0);
      chk("rst_core_mode", core_mode,     1'b0);
      chk("rst_req_ready", bus.req_ready, '0);
   endtask

   task automatic do_reset();
      rst           = 1'b0;
      core_done     = 1'b0;
      core_text_in  = '0;
      bus.rsp_ready = '0;
      for (int i = 0; i < N; i++) begin
         pending[i]  = 1'b0;
         job_key[i]  = '0;
         job_text[i] = '0;
         job_mode[i] = 1'b0;
      end
      drive_reqs();
      repeat (3) @(negedge clk);
      chk_outputs_zero();
      rst     = 1'b1;
      exp_ptr = N - 1;
   endtask

   // One complete job from grant to response handshake. Must be entered at a
   // negedge while the scheduler is idle. lat<=0: core never answers.
   task automatic run_job(input int lat, input int hold, input bit spurious,
                          input int abort_at, input int refill, output int g_obs);
      int           g;
      int           waited;
      int           lat_got;
      int           extra_ld;
      int           exp_lat;
      logic [127:0] ek, et, eres, exp_txt;
      logic         em;
      bit           err_exp;

      drive_reqs();
      #1;
      g      = model_grant();
      g_obs  = -1;
      waited = 0;
      while (bus.req_ready == '0 && waited < 20) begin
         @(negedge clk);
         waited++;
      end
      for (int i = 0; i < N; i++) if (bus.req_ready[i]) g_obs = i;
      chk("grant", bus.req_ready, oh(g));
      chk("busy_idle", busy, 1'b0);
      if (g < 0) g = 0;
      ek = job_key[g];
      et = job_text[g];
      em = job_mode[g];

      @(negedge clk);
      chk("ld_pulse",   core_ld,       1'b1);
      chk("core_key",   core_key,      ek);
      chk("core_text",  core_text_out, et);
      chk("core_mode",  core_mode,     em);
      chk("rdy_load",   bus.req_ready, '0);
      chk("busy_load",  busy,          1'b1);

      // requester g drops or replaces its job mid-run; the latch must hold
      pending[g]  = 1'b0;
      job_key[g]  = rand128();
      job_text[g] = rand128();
      if (refill == 2 || (refill == 1 && $urandom_range(0, 1) == 1)) new_job(g);
      drive_reqs();

      eres    = core_fn(ek, et, em);
      err_exp = (lat <= 0 || lat > TO);
      exp_lat = err_exp ? TO + 1 : lat + 1;
      exp_txt = err_exp ? '0 : eres;
      lat_got = 0;
      extra_ld = 0;

      for (int i = 1; i <= TO + 20; i++) begin
         @(negedge clk);
         if (core_ld) extra_ld++;
         if (i == abort_at) begin
            rst       = 1'b0;
            core_done = 1'b0;
            #1;
            chk_outputs_zero();
            return;
         end
         if (bus.rsp_valid != '0) begin
            lat_got = i;
            break;
         end
         if (i == lat) begin
            core_done    = 1'b1;
            core_text_in = eres;
         end else begin
            core_done    = 1'b0;
            core_text_in = rand128();
         end
         chk("core_key_hold", core_key, ek);
      end
      core_done = 1'b0;

      chk("latency",   lat_got,       exp_lat);
      chk("ld_count",  extra_ld,      0);
      chk("rsp_valid", bus.rsp_valid, oh(g));
      chk("rsp_text",  bus.rsp_text,  exp_txt);
      chk("rsp_err",   bus.rsp_err,   err_exp);
      chk("busy_resp", busy,          1'b1);

      for (int h = 0; h < hold; h++) begin
         bus.rsp_ready = N'($urandom) & ~oh(g);
         if (spurious) begin
            core_done    = 1'b1;
            core_text_in = ~exp_txt ^ rand128();
         end
         @(negedge clk);
         chk("hold_valid", bus.rsp_valid, oh(g));
         chk("hold_text",  bus.rsp_text,  exp_txt);
         chk("hold_err",   bus.rsp_err,   err_exp);
         chk("hold_rdy",   bus.req_ready, '0);
         chk("hold_ld",    core_ld,       1'b0);
      end
      core_done     = 1'b0;
      bus.rsp_ready = oh(g) | N'($urandom);
      @(negedge clk);
      bus.rsp_ready = '0;
      exp_ptr       = g;
      chk("rsp_clear", bus.rsp_valid, '0);
      chk("busy_done", busy,          1'b0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int g_obs;
      int order [5] = '{0, 1, 2, 3, 0};
      int lat, r;

      rst           = 1'b1;
      core_done     = 1'b0;
      core_text_in  = '0;
      bus.rsp_ready = '0;
      bus.req_valid = '0;
      bus.req_key   = '0;
      bus.req_text  = '0;
      bus.req_mode  = '0;
      #2;
      do_reset();

      // FIPS-197 vector on requester 0
      @(negedge clk);
      pending[0]  = 1'b1;
      job_key[0]  = FIPS_K;
      job_text[0] = FIPS_T;
      job_mode[0] = 1'b1;
      run_job(10, 0, 1'b0, 0, 0, g_obs);
      chk("fips_grant", g_obs, 0);

      // all requesters continuously valid
      do_reset();
      @(negedge clk);
      for (int i = 0; i < N; i++) new_job(i);
      for (int j = 0; j < 5; j++) begin
         run_job($urandom_range(1, 6), 0, 1'b0, 0, 2, g_obs);
         chk("rr_order", g_obs, order[j]);
      end

      // core never answers -> timeout
      for (int i = 0; i < N; i++) pending[i] = 1'b0;
      new_job(3);
      run_job(0, 0, 1'b0, 0, 0, g_obs);

      // long response stall with spurious done and competing requests
      new_job(1);
      new_job(2);
      run_job(7, 10, 1'b1, 0, 0, g_obs);

      // done lands exactly on the timeout cycle, then one cycle before/after
      for (int i = 0; i < N; i++) if (!pending[i]) new_job(i);
      run_job(64, 1, 1'b0, 0, 1, g_obs);
      run_job(63, 0, 1'b0, 0, 1, g_obs);
      run_job(65, 0, 1'b0, 0, 1, g_obs);

      // reset three cycles into BUSY, then requester 2 alone
      do_reset();
      @(negedge clk);
      new_job(1);
      run_job(0, 0, 1'b0, 3, 0, g_obs);
      for (int i = 0; i < N; i++) pending[i] = 1'b0;
      new_job(2);
      drive_reqs();
      @(negedge clk);
      chk("rst_hold_rdy",  bus.req_ready, '0);
      chk("rst_hold_busy", busy,          1'b0);
      rst     = 1'b1;
      exp_ptr = N - 1;
      run_job(5, 0, 1'b0, 0, 0, g_obs);
      chk("post_rst_grant", g_obs, 2);

      // randomized traffic
      for (int j = 0; j < 40; j++) begin
         if ($urandom_range(0, 2) == 0) new_job($urandom_range(0, N - 1));
         if (model_grant() < 0) new_job($urandom_range(0, N - 1));
         r = $urandom_range(0, 19);
         case (r)
            0:       lat = 0;
            1:       lat = 64;
            2:       lat = 63;
            3:       lat = 65;
            default: lat = $urandom_range(1, 12);
         endcase
         run_job(lat, $urandom_range(0, 3), 1'($urandom_range(0, 1)), 0, 1, g_obs);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
